m_and_reduce_pipe: RTL and testbench

Parametrised, pipelined N-input AND reduction built as a tree of 3-input AND cells, with a valid/ready handshake and a sideband tag carried alongside each operand word. It replaces ad-hoc wide AND chains in the datapath and in status/flag aggregation, such as "all lanes done" and "all channels idle", where a single-level reduction misses timing. An optional saturating hit counter gives performance and debug visibility.

---
 rtl/m_reduce_pkg.sv | 59 +++++
 rtl/m_and3.sv | 11 +
 rtl/m_and3_level.sv | 22 ++
 rtl/m_and_reduce_pipe.sv | 127 ++++++++++++
 tb/tb_m_and_reduce_pipe.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/m_reduce_pkg.sv
// Shared helpers for the pipelined 3-input AND reduction tree.
// Derives tree depth, padded width and pipeline stage placement from the parameters.
package m_reduce_pkg;

  localparam int unsigned AND_ARITY            = 3;
  localparam int unsigned MIN_LEVELS_PER_STAGE = 1;

  // 3**e.
  function automatic int unsigned pow3(input int unsigned e);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < e; i++) begin
      p = p * AND_ARITY;
    end
    return p;
  endfunction

  // Smallest l with 3**l >= n; clog3(1) == 0.
  function automatic int unsigned clog3(input int unsigned n);
    int unsigned l;
    int unsigned p;
    l = 0;
    p = 1;
    while (p < n) begin
      p = p * AND_ARITY;
      l = l + 1;
    end
    return l;
  endfunction

  // Tree depth; a single bit still gets one level so the output is registered.
  function automatic int unsigned tree_levels(input int unsigned width);
    int unsigned l;
    l = clog3(width);
    return (l == 0) ? 1 : l;
  endfunction

  function automatic int unsigned pad_width(input int unsigned width);
    return pow3(tree_levels(width));
  endfunction

  function automatic int unsigned pipe_stages(input int unsigned levels,
                                              input int unsigned lps);
    return (levels + lps - 1) / lps;
  endfunction

  // A register closes every lps levels, and the last level is always registered.
  function automatic bit is_stage_boundary(input int unsigned level,
                                           input int unsigned levels,
                                           input int unsigned lps);
    return (((level + 1) % lps) == 0) || (level == levels - 1);
  endfunction

  function automatic int unsigned stage_of_level(input int unsigned level,
                                                 input int unsigned lps);
    return level / lps;
  endfunction

endpackage

// File: rtl/m_and3.sv
// 3-input AND cell wrapper; technology mapping of the cell is swapped here only.
module m_and3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic z_c
);

  assign z_c = a & b & c;

endmodule

// File: rtl/m_and3_level.sv
// One combinational level of the reduction tree: IN_W bits to IN_W/3 bits.
module m_and3_level
  import m_reduce_pkg::*;
#(
  parameter int unsigned IN_W = 3
) (
  input  logic [IN_W-1:0]           a,
  output logic [IN_W/AND_ARITY-1:0] z_c
);

  localparam int unsigned OUT_W = IN_W / AND_ARITY;

  for (genvar g = 0; g < OUT_W; g++) begin : g_cell
    m_and3 u_and3 (
      .a   (a[AND_ARITY*g]),
      .b   (a[AND_ARITY*g+1]),
      .c   (a[AND_ARITY*g+2]),
      .z_c (z_c[g])
    );
  end

endmodule

// File: rtl/m_and_reduce_pipe.sv
// Pipelined WIDTH-input AND reduction with valid/ready handshake and sideband tag.
// Optional saturating hit counter (cnt_clr/hit_cnt) is built when M_AND_REDUCE_CNT_EN is defined.
module m_and_reduce_pipe
  import m_reduce_pkg::*;
#(
  parameter int unsigned WIDTH            = 27,
  parameter int unsigned LEVELS_PER_STAGE = 1,
  parameter int unsigned TAG_W            = 4
`ifdef M_AND_REDUCE_CNT_EN
  ,
  parameter int unsigned CNT_W            = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_z,
  output logic [TAG_W-1:0] out_tag
`ifdef M_AND_REDUCE_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt
`endif
);

  localparam int unsigned L = tree_levels(WIDTH);
  localparam int unsigned S = pipe_stages(L, LEVELS_PER_STAGE);
  localparam int unsigned P = pad_width(WIDTH);

  // Whole pipe moves as one; a stalled output freezes every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Pad with ones so the extra leaves never affect the AND.
  logic [P-1:0] pad_c;
  if (P > WIDTH) begin : g_pad
    assign pad_c = {{(P-WIDTH){1'b1}}, in_data};
  end else begin : g_nopad
    assign pad_c = in_data;
  end

  // Valid and tag travel as shift registers alongside the partial results.
  logic [S-1:0]            vld_q;
  logic [S:0]              vld_sh_c;
  logic [S-1:0][TAG_W-1:0] tag_q;
  logic [S:0][TAG_W-1:0]   tag_sh_c;

  assign vld_sh_c = {vld_q, in_valid};
  assign tag_sh_c = {tag_q, in_tag};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else if (adv) begin
      vld_q <= vld_sh_c[S-1:0];
      tag_q <= tag_sh_c[S-1:0];
    end
  end

  // Tree levels; each level either feeds the next directly or through a stage register.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int unsigned IW = pow3(L - k);
    localparam int unsigned OW = IW / AND_ARITY;

    logic [IW-1:0] lvl_in_c;
    logic [OW-1:0] lvl_out_c;
    logic [OW-1:0] fwd;

    if (k == 0) begin : g_src_pad
      assign lvl_in_c = pad_c;
    end else begin : g_src_prev
      assign lvl_in_c = g_lvl[k-1].fwd;
    end

    m_and3_level #(
      .IN_W (IW)
    ) u_level (
      .a   (lvl_in_c),
      .z_c (lvl_out_c)
    );

    if (is_stage_boundary(k, L, LEVELS_PER_STAGE)) begin : g_reg
      logic [OW-1:0] part_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          part_q <= '0;
        end else if (adv) begin
          part_q <= lvl_out_c;
        end
      end

      assign fwd = part_q;
    end else begin : g_comb
      assign fwd = lvl_out_c;
    end
  end

  assign out_valid = vld_q[S-1];
  assign out_tag   = tag_q[S-1];
  assign out_z     = g_lvl[L-1].fwd;

`ifdef M_AND_REDUCE_CNT_EN
  // Saturating count of delivered results with out_z set; clear has priority.
  logic [CNT_W-1:0] hit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else if (cnt_clr) begin
      hit_q <= '0;
    end else if (out_valid && out_ready && out_z && (hit_q != {CNT_W{1'b1}})) begin
      hit_q <= hit_q + CNT_W'(1);
    end
  end

  assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_m_and_reduce_pipe.sv
// Directed self-checking bench: default, padded (WIDTH=28, 2 levels/stage) and single-bit configs.
module tb_m_and_reduce_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // Default config
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_z;
  logic [26:0] a_in_data;
  logic [3:0]  a_in_tag, a_out_tag;
`ifdef M_AND_REDUCE_CNT_EN
  logic        a_cnt_clr;
  logic [1:0]  a_hit_cnt;
`endif

  // WIDTH=28, two levels per stage
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_z;
  logic [27:0] b_in_data;
  logic [3:0]  b_in_tag, b_out_tag;

  // WIDTH=1
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_z;
  logic [0:0]  c_in_data;
  logic [3:0]  c_in_tag, c_out_tag;

  m_and_reduce_pipe #(
    .WIDTH(27), .LEVELS_PER_STAGE(1), .TAG_W(4)
`ifdef M_AND_REDUCE_CNT_EN
    , .CNT_W(2)
`endif
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_z(a_out_z), .out_tag(a_out_tag)
`ifdef M_AND_REDUCE_CNT_EN
    , .cnt_clr(a_cnt_clr), .hit_cnt(a_hit_cnt)
`endif
  );

  m_and_reduce_pipe #(
    .WIDTH(28), .LEVELS_PER_STAGE(2), .TAG_W(4)
`ifdef M_AND_REDUCE_CNT_EN
    , .CNT_W(2)
`endif
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_z(b_out_z), .out_tag(b_out_tag)
`ifdef M_AND_REDUCE_CNT_EN
    , .cnt_clr(1'b0), .hit_cnt()
`endif
  );

  m_and_reduce_pipe #(
    .WIDTH(1), .LEVELS_PER_STAGE(1), .TAG_W(4)
`ifdef M_AND_REDUCE_CNT_EN
    , .CNT_W(2)
`endif
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_z(c_out_z), .out_tag(c_out_tag)
`ifdef M_AND_REDUCE_CNT_EN
    , .cnt_clr(1'b0), .hit_cnt()
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [26:0] bp_data [5];
  int          bp_z    [5];
  int          sent, rcv, nstall, quiet;
  logic        held_z, prev_stall;
  logic [3:0]  held_tag;

  initial begin
    bp_data = '{27'h7FFFFFF, 27'h7FFFFFE, 27'h7FFFFFF, 27'h0000000, 27'h7FFFFFF};
    bp_z    = '{1, 0, 1, 0, 1};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_in_tag = '0; c_out_ready = 1'b1;
`ifdef M_AND_REDUCE_CNT_EN
    a_cnt_clr = 1'b0;
`endif
    tick;
    tick;
    rst_n = 1'b1;

    // Reset state
    check("rst_a_valid", int'(a_out_valid), 0);
    check("rst_a_z",     int'(a_out_z), 0);
    check("rst_a_tag",   int'(a_out_tag), 0);
    check("rst_a_ready", int'(a_in_ready), 1);
    check("rst_b_valid", int'(b_out_valid), 0);
    check("rst_c_valid", int'(c_out_valid), 0);

    // Two-word stream, latency 3
    a_in_valid = 1'b1; a_in_data = 27'h7FFFFFF; a_in_tag = 4'd1;
    tick;
    a_in_data = 27'h7FFFFEF; a_in_tag = 4'd2;
    tick;
    a_in_valid = 1'b0;
    check("s_lat_valid", int'(a_out_valid), 0);
    tick;
    check("s1_valid", int'(a_out_valid), 1);
    check("s1_z",     int'(a_out_z), 1);
    check("s1_tag",   int'(a_out_tag), 1);
    tick;
    check("s2_valid", int'(a_out_valid), 1);
    check("s2_z",     int'(a_out_z), 0);
    check("s2_tag",   int'(a_out_tag), 2);
    tick;
    check("s_drain", int'(a_out_valid), 0);

    // Backpressure: 5 words, out_ready low for cycles 4..7
    sent = 0; rcv = 0; nstall = 0; prev_stall = 1'b0; held_z = 1'b0; held_tag = '0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      a_out_ready = !(cyc >= 4 && cyc <= 7);
      a_in_valid  = (sent < 5);
      a_in_data   = bp_data[(sent < 5) ? sent : 0];
      a_in_tag    = 4'(3 + sent);
      #1;
      if (!a_out_ready && a_out_valid) begin
        nstall++;
        check("bp_in_ready", int'(a_in_ready), 0);
        if (prev_stall) begin
          check("bp_hold_z",   int'(a_out_z), int'(held_z));
          check("bp_hold_tag", int'(a_out_tag), int'(held_tag));
        end
        held_z = a_out_z; held_tag = a_out_tag; prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (a_out_valid && a_out_ready) begin
        if (rcv < 5) begin
          check("bp_z",   int'(a_out_z), bp_z[rcv]);
          check("bp_tag", int'(a_out_tag), 3 + rcv);
        end else begin
          check("bp_extra", rcv, 4);
        end
        rcv++;
      end
      if (a_in_valid && a_in_ready) sent++;
      tick;
    end
    a_in_valid = 1'b0;
    check("bp_count", rcv, 5);
    check("bp_stall_cycles", nstall, 4);

    // Reset mid-flight discards accepted words
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 27'h7FFFFFF;
    for (int i = 0; i < 3; i++) begin
      a_in_tag = 4'(9 + i);
      tick;
    end
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("mr_valid", int'(a_out_valid), 0);
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (!a_out_valid) quiet++;
    end
    check("mr_quiet", quiet, 4);
    a_in_valid = 1'b1; a_in_tag = 4'd12;
    tick;
    a_in_valid = 1'b0;
    check("mr_lat1", int'(a_out_valid), 0);
    tick;
    check("mr_lat2", int'(a_out_valid), 0);
    tick;
    check("mr_valid3", int'(a_out_valid), 1);
    check("mr_tag",    int'(a_out_tag), 12);
    check("mr_z",      int'(a_out_z), 1);
    tick;

    // Padded config: latency 2, bit 27 lands in the padded region's group
    b_in_valid = 1'b1; b_in_data = 28'hFFFFFFF; b_in_tag = 4'd5;
    tick;
    check("b_lat1", int'(b_out_valid), 0);
    b_in_data = 28'h7FFFFFF; b_in_tag = 4'd6;
    tick;
    b_in_valid = 1'b0;
    check("b1_valid", int'(b_out_valid), 1);
    check("b1_z",     int'(b_out_z), 1);
    check("b1_tag",   int'(b_out_tag), 5);
    tick;
    check("b2_valid", int'(b_out_valid), 1);
    check("b2_z",     int'(b_out_z), 0);
    check("b2_tag",   int'(b_out_tag), 6);
    tick;
    check("b_drain", int'(b_out_valid), 0);

    // Single-bit config: latency 1
    c_in_valid = 1'b1; c_in_data = 1'b1; c_in_tag = 4'd1;
    tick;
    check("c1_valid", int'(c_out_valid), 1);
    check("c1_z",     int'(c_out_z), 1);
    check("c1_tag",   int'(c_out_tag), 1);
    c_in_data = 1'b0; c_in_tag = 4'd2;
    tick;
    c_in_valid = 1'b0;
    check("c2_z",   int'(c_out_z), 0);
    check("c2_tag", int'(c_out_tag), 2);
    tick;
    check("c_drain", int'(c_out_valid), 0);

`ifdef M_AND_REDUCE_CNT_EN
    // Hit counter saturates at 3, clear beats a same-cycle hit
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("cnt_rst", int'(a_hit_cnt), 0);
    a_in_valid = 1'b1; a_in_data = 27'h7FFFFFF;
    for (int i = 0; i < 5; i++) begin
      a_in_tag = 4'(i);
      tick;
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    check("cnt_sat", int'(a_hit_cnt), 3);
    a_in_valid = 1'b1; a_in_tag = 4'd7;
    tick;
    a_in_valid = 1'b0;
    tick;
    tick;
    check("cnt_clr_pre_valid", int'(a_out_valid), 1);
    a_cnt_clr = 1'b1;
    tick;
    a_cnt_clr = 1'b0;
    check("cnt_clr_wins", int'(a_hit_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
